// File: rtl/regfile_port_if.sv
// regfile_port_if: writeback requesters, decode read/alloc and register-file write port bundle.
interface regfile_port_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic                 req0_valid, req0_ready;
    logic [ADDR_W-1:0]    req0_rd;
    logic [DATA_W-1:0]    req0_data;
    logic                 req1_valid, req1_ready;
    logic [ADDR_W-1:0]    req1_rd;
    logic [DATA_W-1:0]    req1_data;
    logic                 alloc_valid;
    logic [ADDR_W-1:0]    alloc_rd;
    logic                 rd_req;
    logic [ADDR_W-1:0]    Rs1, Rs2;
    logic                 reg_rd, stall, reg_wr;
    logic [ADDR_W-1:0]    Rd;
    logic [DATA_W-1:0]    DI;
    logic [2**ADDR_W-1:0] pend;

    modport master (
        output req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
               alloc_valid, alloc_rd, rd_req, Rs1, Rs2,
        input  req0_ready, req1_ready, reg_rd, stall, reg_wr, Rd, DI, pend
    );

    modport slave (
        input  req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
               alloc_valid, alloc_rd, rd_req, Rs1, Rs2,
        output req0_ready, req1_ready, reg_rd, stall, reg_wr, Rd, DI, pend
    );
endinterface

// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl: round-robin share of the register-file write port plus a pending
// scoreboard that stalls reads of sources with writes outstanding.
module regfile_port_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input logic           clk,
    input logic           rst,
    regfile_port_if.slave bus
);
    localparam int N = 2**ADDR_W;

    logic         rr, g0, g1;
    logic [N-1:0] set_mask, clr_mask;

    always_comb begin
        g0       = ~rst & bus.req0_valid & (~bus.req1_valid | ~rr);
        g1       = ~rst & bus.req1_valid & (~bus.req0_valid | rr);
        set_mask = bus.alloc_valid ? N'(1) << bus.alloc_rd : '0;
        clr_mask = bus.reg_wr ? N'(1) << bus.Rd : '0;
    end

    assign bus.req0_ready = g0;
    assign bus.req1_ready = g1;
    // No bypass: a bit clearing at the coming edge still blocks this cycle.
    assign bus.stall  = ~rst & bus.rd_req & (bus.pend[bus.Rs1] | bus.pend[bus.Rs2]);
    assign bus.reg_rd = ~rst & bus.rd_req & ~bus.stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr         <= 1'b0;
            bus.reg_wr <= 1'b0;
            bus.Rd     <= '0;
            bus.DI     <= '0;
            bus.pend   <= '0;
        end else begin
            bus.reg_wr <= g0 | g1;
            if (g0 | g1) begin
                rr     <= g0;
                bus.Rd <= g0 ? bus.req0_rd : bus.req1_rd;
                bus.DI <= g0 ? bus.req0_data : bus.req1_data;
            end
            // Set after clear so a fresh allocation survives a same-edge commit.
            bus.pend <= (bus.pend & ~clr_mask) | set_mask;
        end
    end
endmodule

// File: tb/tb_regfile_port_ctrl.sv
// tb_regfile_port_ctrl: table-driven directed vectors plus an alternating-grant sequence.
module tb_regfile_port_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_port_if #(.DATA_W(32), .ADDR_W(4)) bus ();
    regfile_port_ctrl #(.DATA_W(32), .ADDR_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int rst, v0, rd0, d0, v1, rd1, d1, av, ard, rq, rs1, rs2;
        int er0, er1, ewr, erd, edi, est, err, epend;
    } vec_t;

    vec_t tbl[26];
    int passed = 0;
    int total = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input vec_t t);
        rst             = t.rst[0];
        bus.req0_valid  = t.v0[0];
        bus.req0_rd     = 4'(t.rd0);
        bus.req0_data   = 32'(t.d0);
        bus.req1_valid  = t.v1[0];
        bus.req1_rd     = 4'(t.rd1);
        bus.req1_data   = 32'(t.d1);
        bus.alloc_valid = t.av[0];
        bus.alloc_rd    = 4'(t.ard);
        bus.rd_req      = t.rq[0];
        bus.Rs1         = 4'(t.rs1);
        bus.Rs2         = 4'(t.rs2);
    endtask

    initial begin
        //          rst v0 rd0 d0    v1 rd1 d1    av ard rq rs1 rs2 | r0 r1 wr Rd DI    st rr pend
        tbl[0]  = '{1, 1, 4, 'h777, 0, 0, 0,     0, 0,  1, 0,  0,   0, 0, 0, 0, 0,     0, 0, 0};
        tbl[1]  = '{0, 1, 4, 'h777, 0, 0, 0,     0, 0,  0, 0,  0,   1, 0, 0, 0, 0,     0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0,     0, 0, 0,     0, 0,  0, 0,  0,   0, 0, 1, 4, 'h777, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0,     1, 9, 'h99,  0, 0,  0, 0,  0,   0, 1, 0, 4, 'h777, 0, 0, 0};
        tbl[4]  = '{0, 1, 1, 'h33,  1, 7, 'h69,  0, 0,  0, 0,  0,   1, 0, 1, 9, 'h99,  0, 0, 0};
        tbl[5]  = '{0, 1, 1, 'h33,  1, 7, 'h69,  0, 0,  0, 0,  0,   0, 1, 1, 1, 'h33,  0, 0, 0};
        tbl[6]  = '{0, 1, 1, 'h33,  1, 7, 'h69,  0, 0,  0, 0,  0,   1, 0, 1, 7, 'h69,  0, 0, 0};
        tbl[7]  = '{0, 1, 1, 'h33,  1, 7, 'h69,  0, 0,  0, 0,  0,   0, 1, 1, 1, 'h33,  0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0,     0, 0, 0,     0, 0,  0, 0,  0,   0, 0, 1, 7, 'h69,  0, 0, 0};
        tbl[9]  = '{0, 0, 0, 0,     0, 0, 0,     1, 3,  0, 0,  0,   0, 0, 0, 7, 'h69,  0, 0, 0};
        tbl[10] = '{0, 0, 0, 0,     0, 0, 0,     0, 0,  1, 3,  0,   0, 0, 0, 7, 'h69,  1, 0, 'h8};
        tbl[11] = '{0, 0, 0, 0,     1, 3, 'habc, 0, 0,  1, 3,  0,   0, 1, 0, 7, 'h69,  1, 0, 'h8};
        tbl[12] = '{0, 0, 0, 0,     0, 0, 0,     0, 0,  1, 3,  0,   0, 0, 1, 3, 'habc, 1, 0, 'h8};
        tbl[13] = '{0, 0, 0, 0,     0, 0, 0,     0, 0,  1, 3,  0,   0, 0, 0, 3, 'habc, 0, 1, 0};
        tbl[14] = '{0, 1, 5, 'h55,  0, 0, 0,     1, 5,  0, 0,  0,   1, 0, 0, 3, 'habc, 0, 0, 0};
        tbl[15] = '{0, 0, 0, 0,     0, 0, 0,     1, 5,  1, 0,  5,   0, 0, 1, 5, 'h55,  1, 0, 'h20};
        tbl[16] = '{0, 0, 0, 0,     0, 0, 0,     0, 0,  1, 0,  5,   0, 0, 0, 5, 'h55,  1, 0, 'h20};
        tbl[17] = '{0, 1, 2, 'h11,  1, 2, 'h22,  0, 0,  0, 0,  0,   0, 1, 0, 5, 'h55,  0, 0, 'h20};
        tbl[18] = '{0, 1, 2, 'h11,  0, 0, 0,     0, 0,  0, 0,  0,   1, 0, 1, 2, 'h22,  0, 0, 'h20};
        tbl[19] = '{0, 0, 0, 0,     0, 0, 0,     0, 0,  0, 0,  0,   0, 0, 1, 2, 'h11,  0, 0, 'h20};
        tbl[20] = '{0, 1, 6, 'h66,  0, 0, 0,     1, 6,  0, 0,  0,   1, 0, 0, 2, 'h11,  0, 0, 'h20};
        tbl[21] = '{1, 0, 0, 0,     1, 8, 'h88,  0, 0,  1, 5,  0,   0, 0, 1, 6, 'h66,  0, 0, 'h60};
        tbl[22] = '{0, 0, 0, 0,     0, 0, 0,     0, 0,  1, 5,  6,   0, 0, 0, 0, 0,     0, 1, 0};
        tbl[23] = '{0, 0, 0, 0,     0, 0, 0,     1, 15, 0, 0,  0,   0, 0, 0, 0, 0,     0, 0, 0};
        tbl[24] = '{0, 0, 0, 0,     0, 0, 0,     0, 0,  0, 15, 0,   0, 0, 0, 0, 0,     0, 0, 'h8000};
        tbl[25] = '{0, 0, 0, 0,     0, 0, 0,     0, 0,  1, 15, 0,   0, 0, 0, 0, 0,     1, 0, 'h8000};

        drive('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        repeat (2) @(posedge clk);

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("v%0d.req0_ready", i), int'(bus.req0_ready), tbl[i].er0);
            chk($sformatf("v%0d.req1_ready", i), int'(bus.req1_ready), tbl[i].er1);
            chk($sformatf("v%0d.reg_wr", i), int'(bus.reg_wr), tbl[i].ewr);
            chk($sformatf("v%0d.Rd", i), int'(bus.Rd), tbl[i].erd);
            chk($sformatf("v%0d.DI", i), int'(bus.DI), tbl[i].edi);
            chk($sformatf("v%0d.stall", i), int'(bus.stall), tbl[i].est);
            chk($sformatf("v%0d.reg_rd", i), int'(bus.reg_rd), tbl[i].err);
            chk($sformatf("v%0d.pend", i), int'(bus.pend), tbl[i].epend);
        end

        // Both requesters held valid: rr is 0 here, so grants go 0,1,0,1 and
        // the write port follows one cycle later with Rd 1,2,1,2.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive('{0, (k < 4) ? 1 : 0, 1, 'ha0, (k < 4) ? 1 : 0, 2, 'hb0,
                    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
            #1;
            if (k < 4) begin
                chk($sformatf("alt%0d.req0_ready", k), int'(bus.req0_ready), (k % 2 == 0) ? 1 : 0);
                chk($sformatf("alt%0d.req1_ready", k), int'(bus.req1_ready), (k % 2 == 1) ? 1 : 0);
            end
            if (k > 0) begin
                chk($sformatf("alt%0d.reg_wr", k), int'(bus.reg_wr), 1);
                chk($sformatf("alt%0d.Rd", k), int'(bus.Rd), (k % 2 == 1) ? 1 : 2);
                chk($sformatf("alt%0d.DI", k), int'(bus.DI), (k % 2 == 1) ? 'ha0 : 'hb0);
            end
        end
        @(negedge clk);
        #1;
        chk("alt.idle_reg_wr", int'(bus.reg_wr), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/regfile_port_ctrl.md
# regfile_port_ctrl

Controller that shares the register file's single write port between two writeback requesters (ALU result path and load-return path) and gates its read port against pending writes. It drives the register file's write strobe (`reg_wr`), write address (`Rd`) and write data (`DI`) from a registered issue stage. A 16-entry pending scoreboard marks destinations allocated at decode. The block raises `stall` and holds `reg_rd` low while either source register still has a write outstanding. It sits between decode/writeback logic and the register file.

## Interface
Parameters:
- `DATA_W`, 32: register data width.
- `ADDR_W`, 4: register index width; the file has 2**ADDR_W entries.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req0_valid`  in  1: ALU writeback request.
- `req0_ready`  out  1: grant to requester 0; the transfer occurs when valid and ready are both high.
- `req0_rd`  in  ADDR_W: requester 0 destination.
- `req0_data`  in  DATA_W: requester 0 data.
- `req1_valid`, `req1_ready`, `req1_rd`, `req1_data`: same as the requester 0 ports, for the load-return path.
- `alloc_valid`  in  1: decode reserves a destination register.
- `alloc_rd`  in  ADDR_W: register to mark pending.
- `rd_req`  in  1: decode wants to read the sources.
- `Rs1`, `Rs2`  in  ADDR_W: source indices; also passed unchanged to the register file.
- `reg_rd`  out  1: read enable to the register file.
- `stall`  out  1: the read is blocked by a pending source.
- `reg_wr`  out  1: registered write strobe to the register file.
- `Rd`  out  ADDR_W: registered write address.
- `DI`  out  DATA_W: registered write data.
- `pend`  out  2**ADDR_W: scoreboard bits; bit i = register i has a write outstanding.

## Operation
- Arbitration: round-robin between the two requesters.
  - Pointer `rr` (1 bit) selects the preferred requester when both are valid.
  - When only one requester is valid, it is granted regardless of `rr`.
  - After any grant to requester k, `rr` is set to point at the other requester.
  - At most one `reqX_ready` is high per cycle; `ready` is never high without `valid`.
  - The register file never back-pressures, so a valid request is granted within 2 cycles.
- Issue stage: on a grant at edge N, `reg_wr`=1, `Rd`=granted rd and `DI`=granted data are registered at edge N. The register file commits the write at edge N+1.
  - With no grant, `reg_wr`=0 at the next edge; `Rd` and `DI` hold their values.
- Same destination from both requesters in the same cycle: no merging. They are granted in `rr` order on consecutive cycles, and the last grant's data is the value left in the file.
- Scoreboard:
  - Set: `pend[alloc_rd]` is set at the edge where `alloc_valid`=1.
  - Clear: `pend[Rd]` is cleared at the edge where registered `reg_wr`=1, i.e. the commit edge.
  - Set and clear of the same index at the same edge: set wins (a newer allocation is outstanding).
  - Requests to a non-pending register are still issued; the scoreboard does not filter writes.
- Read gating (combinational):
  - `stall` = `rd_req` & (`pend[Rs1]` | `pend[Rs2]`).
  - `reg_rd` = `rd_req` & ~`stall`.
  - Pending bits clearing at the current edge still count as pending for this cycle; there is no bypass.
- Index 0 is an ordinary writable register with no special casing.

## Timing
- Reset (edge with `rst`=1):
  - `reg_wr`=0, `Rd`=0, `DI`=0, `rr`=0 (requester 0 preferred), `pend`=0.
  - `req0_ready`, `req1_ready`, `reg_rd` and `stall` are forced to 0 while `rst` is high.
- Reset mid-operation: an issued but uncommitted write is dropped (`reg_wr` cleared), and all pending bits are cleared.
- Request-to-commit latency is 2 edges: grant at edge N, file write at edge N+1.
- `pend` clears at edge N+1. `stall` drops in the cycle after edge N+1, so a dependent read can fire then.
- Throughput: one write per cycle sustained. With both requesters continuously valid, grants alternate every cycle.

## Test plan
- Reset, then `req0_valid`=1, rd=4, data=0x777 for one cycle → `req0_ready`=1 that cycle; next cycle `reg_wr`=1, `Rd`=4, `DI`=0x777; following cycle `reg_wr`=0.
- Both requesters valid for 4 cycles (req0 rd=1/0x33, req1 rd=7/0x69) → grants in order 0,1,0,1; `reg_wr` stays high with `Rd` alternating 1,7,1,7 one cycle later.
- `alloc_valid`, `alloc_rd`=3, then `rd_req`=1 with `Rs1`=3, `Rs2`=0 → `stall`=1 and `reg_rd`=0. After a req1 write to 3 is granted and committed, `pend[3]`=0 and `reg_rd`=1 in the next cycle.
- `alloc_rd`=5 asserted at the same edge that commits a write to 5 → `pend[5]` remains 1.
- Both requesters target rd=2 (req0 0x11, req1 0x22) with `rr`=1 → req1 is granted first, then req0; `DI` sequence 0x22 then 0x11.
- Assert `rst` the cycle after a grant to rd=6 → `reg_wr`=0 the next cycle, `pend`=0, and no write occurs.
